// File: rtl/tx_srrc_interp.sv
// tx_srrc_interp: 4x interpolating square-root raised-cosine shaper for Gray-coded 4-ASK, one shared MAC.
// Build option: define TX_SAT_EN to saturate the scaled result instead of wrapping it.
module tx_srrc_interp #(
  parameter int WIDTH = 18,
  parameter int NSYM  = 11,
  parameter int ACCW  = 40
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic             sam_clk_en,
  input  logic             sym_clk_en,
  input  logic [1:0]       sym_in,
  output logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             ovr
);

  // state | meaning
  // IDLE  | waiting for a sample request
  // ACC   | one tap product per cycle, k = 0..NSYM-1
  // DONE  | scale accumulator into r
  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  localparam int KW = $clog2(NSYM);
  localparam int PW = 2 * WIDTH;

  state_t                  state_q, state_d;
  logic signed [WIDTH-1:0] s [NSYM];
  logic signed [WIDTH-1:0] sym_map;
  logic signed [WIDTH-1:0] coef_sel;
  logic signed [WIDTH-1:0] s_sel;
  logic signed [WIDTH-1:0] r;
  logic signed [WIDTH-1:0] r_d;
  logic signed [PW-1:0]    prod;
  logic signed [ACCW-1:0]  acc;
  logic [KW-1:0]           k;
  logic [1:0]              ph;
  logic [1:0]              ph_q;
  logic [1:0]              ph_next;

  // Half of the symmetric impulse response; h[i] = h[40-i], taps above 40 are zero.
  function automatic logic signed [WIDTH-1:0] coef(input logic [KW+1:0] idx);
    int m;
    m = int'(idx);
    if (m > 40) m = -1;
    else if (m > 20) m = 40 - m;
    case (m)
      0:  coef = 18'sd500;
      1:  coef = 18'sd1700;
      2:  coef = 18'sd1900;
      3:  coef = 18'sd600;
      4:  coef = -18'sd1800;
      5:  coef = -18'sd3800;
      6:  coef = -18'sd3500;
      7:  coef = -18'sd500;
      8:  coef = 18'sd4000;
      9:  coef = 18'sd7500;
      10: coef = 18'sd7000;
      11: coef = 18'sd2000;
      12: coef = -18'sd7000;
      13: coef = -18'sd15000;
      14: coef = -18'sd17000;
      15: coef = -18'sd9000;
      16: coef = 18'sd11000;
      17: coef = 18'sd40000;
      18: coef = 18'sd71000;
      19: coef = 18'sd94000;
      20: coef = 18'sd103000;
      default: coef = '0;
    endcase
  endfunction

  always_comb begin
    case (sym_in)
      2'b00:   sym_map = -18'sd98304;
      2'b01:   sym_map = -18'sd32768;
      2'b11:   sym_map = 18'sd32768;
      default: sym_map = 18'sd98304;
    endcase
  end

  assign ph_next = sym_clk_en ? 2'd0 : ph + 2'd1;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NSYM; i++) s[i] <= '0;
      ph <= 2'd0;
    end else begin
      if (sym_clk_en) begin
        s[0] <= sym_map;
        for (int i = 1; i < NSYM; i++) s[i] <= s[i-1];
      end
      if (sam_clk_en) ph <= ph_next;
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sam_clk_en) state_d = ACC;
      ACC:     if (k == KW'(NSYM - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign s_sel    = s[k];
  assign coef_sel = coef({k, ph_q});
  assign prod     = coef_sel * s_sel;

  always_comb begin
    r_d = acc[PW-2:WIDTH-1];
`ifdef TX_SAT_EN
    if (!((&acc[ACCW-1:PW-2]) || !(|acc[ACCW-1:PW-2])))
      r_d = acc[ACCW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      acc  <= '0;
      k    <= '0;
      ph_q <= 2'd0;
      r    <= '0;
      y    <= '0;
      ovr  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (sam_clk_en) begin
          acc  <= '0;
          k    <= '0;
          ph_q <= ph_next;
        end
        ACC: begin
          acc <= acc + {{(ACCW-PW){prod[PW-1]}}, prod};
          k   <= k + KW'(1);
        end
        DONE:    r <= r_d;
        default: ;
      endcase
      if (sam_clk_en) y <= r;
      // A request that lands on a running MAC is dropped but remembered.
      if (sam_clk_en && state_q != IDLE) ovr <= 1'b1;
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_tx_srrc_interp.sv
// Directed bench for tx_srrc_interp with a bit-true behavioural model of the shaper.
// Expected values follow the TX_SAT_EN setting of the build.
module tb_tx_srrc_interp;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic        sam_clk_en;
  logic        sym_clk_en;
  logic [1:0]  sym_in;
  logic [17:0] y;
  logic        busy;
  logic        ovr;

  always #5 sys_clk = ~sys_clk;

  tx_srrc_interp dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .sam_clk_en (sam_clk_en),
    .sym_clk_en (sym_clk_en),
    .sym_in     (sym_in),
    .y          (y),
    .busy       (busy),
    .ovr        (ovr)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  int h_half [21] = '{500, 1700, 1900, 600, -1800, -3800, -3500, -500, 4000, 7500,
                      7000, 2000, -7000, -15000, -17000, -9000, 11000, 40000, 71000,
                      94000, 103000};
  int const_tab [4] = '{29100, 29375, 29700, 29375};

  longint      ms [11];
  int          mph;
  logic [17:0] res_last, res_prev, my;
  int          t_acc;
  logic        m_ovr;

  function automatic longint h_of(input int i);
    if (i > 40) return 0;
    return longint'(h_half[(i <= 20) ? i : 40 - i]);
  endfunction

  function automatic longint map_sym(input logic [1:0] v);
    case (v)
      2'b00:   return -98304;
      2'b01:   return -32768;
      2'b11:   return 32768;
      default: return 98304;
    endcase
  endfunction

  function automatic logic [17:0] model_result();
    longint a, v;
    a = 0;
    for (int kk = 0; kk < 11; kk++) a += h_of(4 * kk + mph) * ms[kk];
    v = a >>> 17;
`ifdef TX_SAT_EN
    if (v > 131071)  v = 131071;
    if (v < -131072) v = -131072;
`endif
    return v[17:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 11; i++) ms[i] = 0;
    mph      = 0;
    res_last = '0;
    res_prev = '0;
    my       = '0;
    t_acc    = cyc - 1000;
    m_ovr    = 1'b0;
  endtask

  task automatic tick();
    @(posedge sys_clk);
    cyc++;
    @(negedge sys_clk);
  endtask

  task automatic gap(input int n);
    repeat (n) tick();
  endtask

  // One sample request; the model advances alongside the DUT.
  task automatic strobe(input logic se, input logic [1:0] sv);
    sam_clk_en = 1'b1;
    sym_clk_en = se;
    sym_in     = sv;
    tick();
    sam_clk_en = 1'b0;
    sym_clk_en = 1'b0;
    if (se) begin
      for (int i = 10; i > 0; i--) ms[i] = ms[i-1];
      ms[0] = map_sym(sv);
      mph = 0;
    end else begin
      mph = (mph + 1) % 4;
    end
    if (cyc - t_acc >= 13) begin
      my       = res_last;
      res_prev = res_last;
      res_last = model_result();
      t_acc    = cyc;
    end else begin
      my    = res_prev;
      m_ovr = 1'b1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    gap(2);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    gap(2);
    n_cmp++; if (y !== 18'd0)  begin n_err++; $display("FAIL reset_y: got %0d expected 0", $signed(y)); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (ovr !== 1'b0)  begin n_err++; $display("FAIL reset_ovr: got %b expected 0", ovr); end
    reset = 1'b0;
    model_reset();
    tick();
    n_cmp++; if (y !== 18'd0) begin n_err++; $display("FAIL reset_release_y: got %0d expected 0", $signed(y)); end
  endtask

  task automatic test_constant();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      for (int p = 0; p < 4; p++) begin
        strobe(p == 0, 2'b11);
        n_cmp++;
        if (y !== my) begin
          n_err++;
          $display("FAIL const_model s%0d p%0d: got %0d expected %0d", i, p, $signed(y), $signed(my));
        end
        if (i >= 11) begin
          n_cmp++;
          if (y !== 18'(const_tab[(p + 3) % 4])) begin
            n_err++;
            $display("FAIL const_hand s%0d p%0d: got %0d expected %0d", i, p, $signed(y), const_tab[(p + 3) % 4]);
          end
        end
        gap(15);
      end
    end
  endtask

  task automatic test_impulse();
    logic [1:0] sv;
    do_reset();
    for (int i = 0; i < 28; i++) begin
      sv = (i == 5) ? 2'b10 : ((i % 2 == 0) ? 2'b01 : 2'b11);
      for (int p = 0; p < 4; p++) begin
        strobe(p == 0, sv);
        n_cmp++;
        if (y !== my) begin
          n_err++;
          $display("FAIL impulse s%0d p%0d: got %0d expected %0d", i, p, $signed(y), $signed(my));
        end
        gap(15);
      end
    end
  endtask

  task automatic test_overrun();
    int bcnt;
    int bound;
    logic [1:0] pre [4] = '{2'b11, 2'b00, 2'b10, 2'b01};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      strobe(1'b1, pre[i]);
      gap(15);
    end
    strobe(1'b1, 2'b10);
    bcnt = busy ? 1 : 0;
    for (int c = 1; c < 5; c++) begin
      tick();
      if (busy) bcnt++;
    end
    strobe(1'b0, 2'b00);
    if (busy) bcnt++;
    n_cmp++;
    if (y !== my) begin n_err++; $display("FAIL overrun_y_dropped: got %0d expected %0d", $signed(y), $signed(my)); end
    n_cmp++;
    if (ovr !== 1'b1) begin n_err++; $display("FAIL overrun_ovr: got %b expected 1", ovr); end
    bound = 0;
    while (busy && bound < 30) begin
      tick();
      if (busy) bcnt++;
      bound++;
    end
    n_cmp++;
    if (bcnt != 12) begin n_err++; $display("FAIL overrun_busy_len: got %0d expected 12", bcnt); end
    strobe(1'b0, 2'b00);
    n_cmp++;
    if (y !== my) begin n_err++; $display("FAIL overrun_first_result: got %0d expected %0d", $signed(y), $signed(my)); end
    n_cmp++;
    if (ovr !== 1'b1) begin n_err++; $display("FAIL overrun_sticky: got %b expected 1", ovr); end
    gap(15);
  endtask

  task automatic test_stress();
    logic [1:0] seq [11] = '{2'b10, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10};
    int exp_v;
`ifdef TX_SAT_EN
    exp_v = 131071;
`else
    exp_v = -111544;
`endif
    do_reset();
    for (int i = 0; i < 11; i++) begin
      for (int p = 0; p < 4; p++) begin
        strobe(p == 0, seq[i]);
        n_cmp++;
        if (y !== my) begin
          n_err++;
          $display("FAIL stress_model s%0d p%0d: got %0d expected %0d", i, p, $signed(y), $signed(my));
        end
        gap(15);
      end
    end
    n_cmp++;
    if (y !== 18'(exp_v)) begin n_err++; $display("FAIL stress_phase2: got %0d expected %0d", $signed(y), exp_v); end
  endtask

  task automatic test_min_period();
    do_reset();
    for (int n = 0; n < 1000; n++) begin
      strobe((n % 4) == 0, 2'($urandom_range(0, 3)));
      n_cmp++;
      if (y !== my) begin
        n_err++;
        $display("FAIL min_period n%0d: got %0d expected %0d", n, $signed(y), $signed(my));
      end
      gap(12);
    end
    n_cmp++;
    if (ovr !== 1'b0) begin n_err++; $display("FAIL min_period_ovr: got %b expected 0", ovr); end
  endtask

  task automatic test_reset_mid_acc();
    strobe(1'b0, 2'b00);
    gap(2);
    strobe(1'b0, 2'b00);
    gap(2);
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midacc_busy: got %b expected 0", busy); end
    n_cmp++; if (y !== 18'd0)   begin n_err++; $display("FAIL midacc_y: got %0d expected 0", $signed(y)); end
    n_cmp++; if (ovr !== 1'b0)  begin n_err++; $display("FAIL midacc_ovr: got %b expected 0", ovr); end
    @(negedge sys_clk);
    tick();
    reset = 1'b0;
    model_reset();
    strobe(1'b1, 2'b10);
    n_cmp++; if (y !== 18'd0) begin n_err++; $display("FAIL midacc_first_strobe: got %0d expected 0", $signed(y)); end
    gap(15);
    strobe(1'b0, 2'b00);
    n_cmp++; if (y !== my) begin n_err++; $display("FAIL midacc_second_model: got %0d expected %0d", $signed(y), $signed(my)); end
    n_cmp++; if (y !== 18'd375) begin n_err++; $display("FAIL midacc_second_hand: got %0d expected 375", $signed(y)); end
    gap(15);
  endtask

  initial begin
    reset      = 1'b1;
    sam_clk_en = 1'b0;
    sym_clk_en = 1'b0;
    sym_in     = 2'b00;
    model_reset();
    @(negedge sys_clk);
    test_reset();
    test_constant();
    test_impulse();
    test_overrun();
    test_stress();
    test_min_period();
    test_reset_mid_acc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
